// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for a 5-stage RV32I core
//            (F/D/E/M/W). Generates per-stage stall/flush controls and the
//            E-stage operand forwarding selects. Handles load-use hazards,
//            taken-branch/jump redirects, variable-latency data-memory waits,
//            a post-reset boot bubble sequence and a sticky memory-timeout
//            error halt.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            Rs1D_i/Rs2D_i              - source regs of the instruction in D
//            Rs1E_i/Rs2E_i              - source regs of the instruction in E
//            RdE_i/RdM_i/RdW_i          - destination regs in E/M/W
//            RegWriteM_i/RegWriteW_i    - writeback enables in M/W
//            ResultSrcE_i               - result select of the E instruction
//            PCSrcE_i                   - taken branch / jump resolved in E
//            MemReqM_i/MemReadyM_i      - data-memory request / completion
//            StallF/D/E/M_o             - hold stage register
//            FlushD/E/W_o               - load bubble into stage register
//            ForwardAE_o/ForwardBE_o    - 00 regfile, 01 W result, 10 M ALU
//            MemErr_o                   - sticky memory-timeout error
//            StallCnt_o                 - saturating fetch-stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
   parameter int         REG_ADDR_WIDTH = 5,
   parameter int         BOOT_CYCLES    = 2,
   parameter int         MEM_TIMEOUT    = 16,
   parameter logic [1:0] LOAD_RESULTSRC = 2'b01,
   parameter int         CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
   input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
   input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
   input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
   input  logic                      RegWriteM_i,
   input  logic                      RegWriteW_i,
   input  logic [1:0]                ResultSrcE_i,
   input  logic                      PCSrcE_i,
   input  logic                      MemReqM_i,
   input  logic                      MemReadyM_i,
   output logic                      StallF_o,
   output logic                      StallD_o,
   output logic                      StallE_o,
   output logic                      StallM_o,
   output logic                      FlushD_o,
   output logic                      FlushE_o,
   output logic                      FlushW_o,
   output logic [1:0]                ForwardAE_o,
   output logic [1:0]                ForwardBE_o,
   output logic                      MemErr_o,
   output logic [CNT_WIDTH-1:0]      StallCnt_o
);

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [BW-1:0]        C_BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [WW-1:0]        C_WAIT_LAST = WW'(MEM_TIMEOUT - 1);
   localparam logic [WW-1:0]        C_WAIT_ONE  = WW'(1);
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [REG_ADDR_WIDTH-1:0] C_X0   = '0;

   typedef enum logic [1:0] {
      S_BOOT    = 2'd0,
      S_RUN     = 2'd1,
      S_MEMWAIT = 2'd2,
      S_ERROR   = 2'd3
   } state_t;

   state_t                 state_q;
   logic [BW-1:0]          boot_cnt_q;
   logic [WW-1:0]          wait_cnt_q;
   logic                   err_q;
   logic [CNT_WIDTH-1:0]   stall_cnt_q;

   logic                   lw_stall;
   logic                   redirect;
   logic                   mem_busy;
   logic [1:0]             fwd_a;
   logic [1:0]             fwd_b;

   // M-stage result is newer than W, so it wins when both match.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_WIDTH-1:0] rs,
      input logic [REG_ADDR_WIDTH-1:0] rd_m,
      input logic                      we_m,
      input logic [REG_ADDR_WIDTH-1:0] rd_w,
      input logic                      we_w
   );
      if (we_m && (rd_m != C_X0) && (rd_m == rs))
         return 2'b10;
      else if (we_w && (rd_w != C_X0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      fwd_a    = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      fwd_b    = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      lw_stall = (ResultSrcE_i == LOAD_RESULTSRC) && (RdE_i != C_X0) &&
                 ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
      redirect = PCSrcE_i;
      mem_busy = MemReqM_i && !MemReadyM_i;
   end

   // Stage controls are a function of the current state and live inputs.
   always_comb begin
      StallF_o    = 1'b0;
      StallD_o    = 1'b0;
      StallE_o    = 1'b0;
      StallM_o    = 1'b0;
      FlushD_o    = 1'b0;
      FlushE_o    = 1'b0;
      FlushW_o    = 1'b0;
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;

      if (!rst_n || (state_q == S_BOOT)) begin
         StallF_o = 1'b1;
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
      end else if (state_q == S_ERROR) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         StallE_o = 1'b1;
         StallM_o = 1'b1;
         FlushW_o = 1'b1;
      end else begin
         ForwardAE_o = fwd_a;
         ForwardBE_o = fwd_b;
         // Memory wait freezes F..M and holds off redirects and load-use
         // bubbles until the access finishes; W gets a bubble meanwhile.
         if ((state_q == S_RUN && mem_busy) ||
             (state_q == S_MEMWAIT && !MemReadyM_i)) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
         end else if (redirect) begin
            // Stalling F here would drop the branch target, so the
            // load-use stall is discarded along with the wrong path.
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
         end else if (lw_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         boot_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (StallF_o && ((state_q == S_RUN) || (state_q == S_MEMWAIT)) &&
             (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + C_CNT_ONE;

         case (state_q)
            S_BOOT: begin
               if (boot_cnt_q == C_BOOT_LAST) begin
                  state_q    <= S_RUN;
                  boot_cnt_q <= '0;
               end else begin
                  boot_cnt_q <= boot_cnt_q + BW'(1);
               end
            end
            S_RUN: begin
               if (mem_busy) begin
                  state_q    <= S_MEMWAIT;
                  wait_cnt_q <= C_WAIT_ONE;
               end
            end
            S_MEMWAIT: begin
               if (MemReadyM_i) begin
                  state_q    <= S_RUN;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == C_WAIT_LAST) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + C_WAIT_ONE;
               end
            end
            S_ERROR: begin
               err_q <= 1'b1;
            end
            default: begin
               state_q <= S_ERROR;
            end
         endcase
      end
   end

   // Reset forces the architectural outputs to their boot values at once.
   assign MemErr_o   = err_q & rst_n;
   assign StallCnt_o = rst_n ? stall_cnt_q : '0;

endmodule

`default_nettype wire
